jay_core_seq: RTL and testbench

// - Parametrised multi-cycle successor to the single-cycle JAY core: same 9-bit ISA, configurable data/PC width.
// - Adds start/done handshake, external sync imem/dmem ports, programmable end address, retired-instruction counter.
// - Top of the processor subsystem; testbench/SoC owns instruction ROM and data memory.

---
 rtl/jay_core_seq.sv | 217 +++++++++++++++++++++
 tb/tb_jay_core_seq.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jay_core_seq.sv
// jay_core_seq: multi-cycle JAY processor core.
// 9-bit instructions {op[2:0], ra[2:0], rb[2:0]}, eight DW-bit registers,
// PW-bit program counter, start/done handshake, synchronous external
// instruction and data memories, saturating retired-instruction counter.
// Optional feature: define JAY_PARITY_FLAG_EN to keep a registered parity
// flag of the last register-file write result on parity_o.
module jay_core_seq #(
    parameter int DW       = 8,
    parameter int PW       = 12,
    parameter int END_ADDR = 318,
    parameter int CW       = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    output logic          busy,
    output logic          done,
    output logic [PW-1:0] imem_addr,
    input  logic [8:0]    imem_rdata,
    output logic [DW-1:0] dmem_addr,
    output logic [DW-1:0] dmem_wdata,
    output logic          dmem_we,
    output logic          dmem_re,
    input  logic [DW-1:0] dmem_rdata,
    output logic [CW-1:0] retired,
    output logic          parity_o
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_EXEC  = 3'd2;
    localparam logic [2:0] S_MEMRD = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_XOR = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_SHL = 3'b011;
    localparam logic [2:0] OP_LDI = 3'b100;
    localparam logic [2:0] OP_LD  = 3'b101;
    localparam logic [2:0] OP_ST  = 3'b110;
    localparam logic [2:0] OP_JZ  = 3'b111;

    localparam logic [PW:0] END_LIM = (PW+1)'(END_ADDR);

    logic [2:0]    state_q, state_d;
    logic [PW-1:0] pc_q, pc_d;
    logic          sc_q, sc_d;
    logic [2:0]    ld_ra_q, ld_ra_d;
    logic [CW-1:0] retired_q;
    logic [DW-1:0] regs_q [8];

    logic [2:0]    op, ra, rb;
    logic [DW-1:0] rd_a, rd_b;
    logic [DW:0]   sum;
    logic [PW:0]   npc;
    logic          at_end;
    logic          is_exec;
    logic          wr_en;
    logic [2:0]    wr_sel;
    logic [DW-1:0] wr_data;
    logic          retire;

    assign op      = imem_rdata[8:6];
    assign ra      = imem_rdata[5:3];
    assign rb      = imem_rdata[2:0];
    assign rd_a    = regs_q[ra];
    assign rd_b    = regs_q[rb];
    assign sum     = {1'b0, rd_a} + {1'b0, rd_b};
    assign is_exec = (state_q == S_EXEC);

    // Next PC: taken JZ jumps to r[rb]; everything else falls through. The
    // extra top bit catches a PC wrap so it ends the program instead.
    always_comb begin
        npc = (PW+1)'(pc_q) + (PW+1)'(1);
        if (is_exec && op == OP_JZ && rd_a == '0) begin
            npc = {1'b0, PW'(rd_b)};
        end
    end

    assign at_end = npc[PW] || (npc > END_LIM);

    // FSM sequencing and instruction execute decode.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        state_d = state_q;
        pc_d    = pc_q;
        sc_d    = sc_q;
        ld_ra_d = ld_ra_q;
        wr_en   = 1'b0;
        wr_sel  = ra;
        wr_data = '0;
        retire  = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (req) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                end
            end
            S_FETCH: state_d = S_EXEC;
            S_EXEC: begin
                case (op)
                    OP_ADD: begin
                        wr_en   = 1'b1;
                        wr_data = sum[DW-1:0];
                        sc_d    = sum[DW];
                    end
                    OP_XOR: begin
                        wr_en   = 1'b1;
                        wr_data = rd_a ^ rd_b;
                    end
                    OP_AND: begin
                        wr_en   = 1'b1;
                        wr_data = rd_a & rd_b;
                    end
                    OP_SHL: begin
                        wr_en   = 1'b1;
                        wr_data = {rd_a[DW-2:0], sc_q};
                        sc_d    = rd_a[DW-1];
                    end
                    OP_LDI: begin
                        wr_en   = 1'b1;
                        wr_data = DW'(rb);
                    end
                    OP_LD: ld_ra_d = ra;
                    default: ;
                endcase
                if (op == OP_LD) begin
                    state_d = S_MEMRD;
                end else begin
                    retire = 1'b1;
                end
            end
            S_MEMRD: begin
                wr_en   = 1'b1;
                wr_sel  = ld_ra_q;
                wr_data = dmem_rdata;
                retire  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
        if (retire) begin
            if (at_end) begin
                state_d = S_DONE;
            end else begin
                state_d = S_FETCH;
                pc_d    = npc[PW-1:0];
            end
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            sc_q    <= 1'b0;
            ld_ra_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            sc_q    <= sc_d;
            ld_ra_q <= ld_ra_d;
        end
    end

    // Register file write port; written at the end of EXEC or MEMRD.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: the register file is flops, not a RAM, so it can and must
        // be cleared by reset; programs rely on r0..r7 starting at zero.
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[wr_sel] <= wr_data;
        end
    end

    // Retired-instruction counter, saturating at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retired_q <= '0;
        end else if (retire && retired_q != '1) begin
            retired_q <= retired_q + 1'b1;
        end
    end

`ifdef JAY_PARITY_FLAG_EN
    logic parity_q;

    // Parity of the most recent register-file write result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parity_q <= 1'b0;
        end else if (wr_en) begin
            parity_q <= ^wr_data;
        end
    end

    assign parity_o = parity_q;
`else
    assign parity_o = 1'b0;
`endif

    assign busy       = (state_q == S_FETCH) || is_exec || (state_q == S_MEMRD);
    assign done       = (state_q == S_DONE);
    assign imem_addr  = pc_q;
    assign dmem_re    = is_exec && (op == OP_LD);
    assign dmem_we    = is_exec && (op == OP_ST);
    assign dmem_addr  = (dmem_re || dmem_we) ? rd_b : '0;
    assign dmem_wdata = dmem_we ? rd_a : '0;
    assign retired    = retired_q;

endmodule

// File: tb/tb_jay_core_seq.sv
// Directed bench for jay_core_seq. u_a (END_ADDR=2) runs a series of
// three-instruction programs that share register state across restarts;
// u_b (DW=12, CW=2) covers jumps, end-address overrun and counter saturation.
module tb_jay_core_seq;

`ifdef JAY_PARITY_FLAG_EN
    localparam logic PAR_EN = 1'b1;
`else
    localparam logic PAR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // ---------------- u_a: DW=8, PW=12, END_ADDR=2, CW=16 ----------------
    logic        req_a = 1'b0;
    logic        busy_a, done_a, we_a, re_a, par_a;
    logic [11:0] iaddr_a;
    logic [8:0]  irdata_a = '0;
    logic [7:0]  daddr_a, dwdata_a, drdata_a;
    logic [15:0] ret_a;
    logic [8:0]  rom_a [0:3];
    logic [7:0]  mem_a [0:255];
    logic [15:0] st_q [$];

    jay_core_seq #(.DW(8), .PW(12), .END_ADDR(2), .CW(16)) u_a (
        .clk(clk), .reset(reset), .req(req_a), .busy(busy_a), .done(done_a),
        .imem_addr(iaddr_a), .imem_rdata(irdata_a),
        .dmem_addr(daddr_a), .dmem_wdata(dwdata_a), .dmem_we(we_a), .dmem_re(re_a),
        .dmem_rdata(drdata_a), .retired(ret_a), .parity_o(par_a)
    );

    always @(posedge clk) begin
        irdata_a <= rom_a[iaddr_a[1:0]];
        if (re_a) drdata_a <= mem_a[daddr_a];
        if (we_a) mem_a[daddr_a] <= dwdata_a;
    end

    always @(negedge clk) begin
        if (we_a) st_q.push_back({daddr_a, dwdata_a});
    end

    // ---------------- u_b: DW=12, PW=12, END_ADDR=318, CW=2 ---------------
    logic        req_b = 1'b0;
    logic        busy_b, done_b, we_b, re_b, par_b;
    logic [11:0] iaddr_b, daddr_b, dwdata_b;
    logic [11:0] drdata_b = '0;
    logic [8:0]  irdata_b = '0;
    logic [1:0]  ret_b;
    logic [8:0]  rom_b [0:31];

    jay_core_seq #(.DW(12), .PW(12), .END_ADDR(318), .CW(2)) u_b (
        .clk(clk), .reset(reset), .req(req_b), .busy(busy_b), .done(done_b),
        .imem_addr(iaddr_b), .imem_rdata(irdata_b),
        .dmem_addr(daddr_b), .dmem_wdata(dwdata_b), .dmem_we(we_b), .dmem_re(re_b),
        .dmem_rdata(drdata_b), .retired(ret_b), .parity_o(par_b)
    );

    always @(posedge clk) irdata_b <= rom_b[iaddr_b[4:0]];

    function automatic logic [8:0] ins(input logic [2:0] op, input logic [2:0] ra,
                                       input logic [2:0] rb);
        return {op, ra, rb};
    endfunction

    // Load a 3-instruction program into u_a, pulse req for one cycle and
    // wait (bounded) for done; checks run length and retired count.
    task automatic run_a(input string name, input logic [8:0] i0, input logic [8:0] i1,
                         input logic [8:0] i2, input int exp_cyc, input logic [15:0] exp_ret);
        int cyc;
        rom_a[0] = i0;
        rom_a[1] = i1;
        rom_a[2] = i2;
        st_q.delete();
        @(negedge clk) req_a = 1'b1;
        @(negedge clk) req_a = 1'b0;
        cyc = 0;
        while (!done_a && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc !== exp_cyc) begin
            failures++;
            $display("FAIL %s_cycles: got %0d expected %0d", name, cyc, exp_cyc);
        end
        checks++;
        if (ret_a !== exp_ret) begin
            failures++;
            $display("FAIL %s_retired: got %0d expected %0d", name, ret_a, exp_ret);
        end
    endtask

    task automatic check_stores(input string name, input int n, input logic [15:0] s0,
                                input logic [15:0] s1);
        checks++;
        if (st_q.size() != n) begin
            failures++;
            $display("FAIL %s_store_count: got %0d expected %0d", name, st_q.size(), n);
        end else begin
            checks++;
            if (st_q[0] !== s0) begin
                failures++;
                $display("FAIL %s_store0: got addr/data %h expected %h", name, st_q[0], s0);
            end
            if (n > 1) begin
                checks++;
                if (st_q[1] !== s1) begin
                    failures++;
                    $display("FAIL %s_store1: got addr/data %h expected %h", name, st_q[1], s1);
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy_a, done_a, we_a, re_a, par_a, busy_b, done_b} !== 7'b0) begin
            failures++;
            $display("FAIL reset_flags: got %b expected 0000000",
                     {busy_a, done_a, we_a, re_a, par_a, busy_b, done_b});
        end
        checks++;
        if ({iaddr_a, daddr_a, dwdata_a, ret_a} !== '0) begin
            failures++;
            $display("FAIL reset_buses_a: got %h expected 0", {iaddr_a, daddr_a, dwdata_a, ret_a});
        end
        checks++;
        if ({iaddr_b, ret_b} !== '0) begin
            failures++;
            $display("FAIL reset_buses_b: got %h expected 0", {iaddr_b, ret_b});
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Reset asserted while an LD sits in MEMRD.
    task automatic test_reset_mid_ld();
        mem_a[0] = 8'h5A;
        rom_a[0] = ins(3'd5, 3'd4, 3'd0);
        rom_a[1] = ins(3'd4, 3'd1, 3'd1);
        rom_a[2] = ins(3'd4, 3'd1, 3'd1);
        @(negedge clk) req_a = 1'b1;
        @(negedge clk) req_a = 1'b0;
        @(negedge clk);
        checks++;
        if (re_a !== 1'b1 || daddr_a !== 8'h00) begin
            failures++;
            $display("FAIL midld_strobe: got re=%b addr=%h expected re=1 addr=00", re_a, daddr_a);
        end
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({busy_a, done_a, re_a, we_a} !== 4'b0 || ret_a !== '0 || iaddr_a !== '0) begin
            failures++;
            $display("FAIL midld_reset: got flags=%b ret=%0d pc=%0d expected 0/0/0",
                     {busy_a, done_a, re_a, we_a}, ret_a, iaddr_a);
        end
        @(negedge clk) reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_program_a();
        run_a("add", ins(3'd4, 3'd1, 3'd5), ins(3'd4, 3'd2, 3'd3), ins(3'd0, 3'd1, 3'd2), 6, 16'd3);
        checks++;
        if (iaddr_a !== 12'd2 || par_a !== PAR_EN) begin
            failures++;
            $display("FAIL add_done_state: got pc=%0d par=%b expected pc=2 par=%b",
                     iaddr_a, par_a, PAR_EN);
        end
        // r1 should now be 8; store it to its own address.
        run_a("store", ins(3'd6, 3'd1, 3'd1), ins(3'd4, 3'd3, 3'd4), ins(3'd6, 3'd3, 3'd3), 6, 16'd6);
        check_stores("store", 2, 16'h0808, 16'h0404);
    endtask

    task automatic test_shl_wrap();
        run_a("shl1", ins(3'd4, 3'd1, 3'd7), ins(3'd3, 3'd1, 3'd0), ins(3'd3, 3'd1, 3'd0), 6, 16'd9);
        run_a("shl2", ins(3'd3, 3'd1, 3'd0), ins(3'd3, 3'd1, 3'd0), ins(3'd3, 3'd1, 3'd0), 6, 16'd12);
        // Sixth shift gives 0xC0 (sc=0 shifted in), ADD r1,r1 -> 0x80, sc=1.
        run_a("wrap", ins(3'd3, 3'd1, 3'd0), ins(3'd0, 3'd1, 3'd1), ins(3'd6, 3'd1, 3'd1), 6, 16'd15);
        check_stores("wrap", 1, 16'h8080, 16'h0000);
    endtask

    task automatic test_ld_logic();
        // SHL pulls sc=1 in: r1 = 0x01. LD r5 <- [r3=4] reads 4; 7 cycles.
        run_a("ld", ins(3'd3, 3'd1, 3'd0), ins(3'd6, 3'd1, 3'd1), ins(3'd5, 3'd5, 3'd3), 7, 16'd18);
        check_stores("ld", 1, 16'h0101, 16'h0000);
        run_a("xor", ins(3'd6, 3'd5, 3'd5), ins(3'd1, 3'd5, 3'd1), ins(3'd6, 3'd5, 3'd5), 6, 16'd21);
        check_stores("xor", 2, 16'h0404, 16'h0505);
        checks++;
        if (par_a !== 1'b0) begin
            failures++;
            $display("FAIL xor_parity: got %b expected 0", par_a);
        end
        // r4 was the LD target interrupted by reset: must be 0.
        run_a("and", ins(3'd2, 3'd5, 3'd3), ins(3'd6, 3'd5, 3'd5), ins(3'd6, 3'd4, 3'd4), 6, 16'd24);
        check_stores("and", 2, 16'h0404, 16'h0000);
    endtask

    // req held high: DONE restarts immediately and req is ignored while busy.
    task automatic test_back_to_back();
        int cyc;
        rom_a[0] = ins(3'd4, 3'd7, 3'd1);
        rom_a[1] = ins(3'd4, 3'd7, 3'd1);
        rom_a[2] = ins(3'd4, 3'd7, 3'd1);
        @(negedge clk) req_a = 1'b1;
        @(negedge clk);
        cyc = 0;
        while (!done_a && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
        checks++;
        if (done_a !== 1'b0 || busy_a !== 1'b1 || iaddr_a !== 12'd0) begin
            failures++;
            $display("FAIL b2b_restart: got done=%b busy=%b pc=%0d expected 0/1/0",
                     done_a, busy_a, iaddr_a);
        end
        cyc = 1;
        while (!done_a && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        req_a = 1'b0;
        checks++;
        if (cyc !== 7) begin
            failures++;
            $display("FAIL b2b_cycles: got %0d expected 7", cyc);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (done_a !== 1'b1 || ret_a !== 16'd30) begin
            failures++;
            $display("FAIL b2b_hold: got done=%b ret=%0d expected 1/30", done_a, ret_a);
        end
    endtask

    task automatic test_jump_end();
        int cyc;
        for (int i = 0; i < 32; i++) rom_b[i] = ins(3'd4, 3'd7, 3'd7);
        rom_b[0]  = ins(3'd4, 3'd6, 3'd5);
        rom_b[1]  = ins(3'd0, 3'd6, 3'd6);
        rom_b[2]  = ins(3'd7, 3'd0, 3'd6);
        rom_b[10] = ins(3'd4, 3'd6, 3'd3);
        for (int i = 11; i < 14; i++) rom_b[i] = ins(3'd0, 3'd6, 3'd6);
        rom_b[14] = ins(3'd4, 3'd5, 3'd1);
        rom_b[15] = ins(3'd0, 3'd6, 3'd5);
        for (int i = 16; i < 20; i++) rom_b[i] = ins(3'd0, 3'd6, 3'd6);
        rom_b[20] = ins(3'd7, 3'd0, 3'd6);
        @(negedge clk) req_b = 1'b1;
        @(negedge clk) req_b = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (iaddr_b !== 12'd10 || busy_b !== 1'b1) begin
            failures++;
            $display("FAIL jz_taken: got pc=%0d busy=%b expected pc=10 busy=1", iaddr_b, busy_b);
        end
        cyc = 6;
        while (!done_b && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc !== 28) begin
            failures++;
            $display("FAIL jz_end_cycles: got %0d expected 28", cyc);
        end
        checks++;
        if (iaddr_b !== 12'd20 || done_b !== 1'b1) begin
            failures++;
            $display("FAIL jz_end_pc: got pc=%0d done=%b expected pc=20 done=1", iaddr_b, done_b);
        end
        checks++;
        if (ret_b !== 2'd3) begin
            failures++;
            $display("FAIL retired_sat: got %0d expected 3", ret_b);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem_a[i] = '0;
        for (int i = 0; i < 4; i++) rom_a[i] = '0;
        for (int i = 0; i < 32; i++) rom_b[i] = '0;
        test_reset();
        test_reset_mid_ld();
        test_program_a();
        test_shl_wrap();
        test_ld_logic();
        test_back_to_back();
        test_jump_end();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
